// File: rtl/quad_decoder_array_if.sv
// Signal bundle between the encoder input synchronisers, the decoder array and user logic.
// The master drives phases, mode and clears; the slave (decoder) returns steps, position and error.
interface quad_decoder_array_if #(
  parameter int NUM_CH    = 2,
  parameter int POS_WIDTH = 8
);
  logic [NUM_CH-1:0]           a_sync;
  logic [NUM_CH-1:0]           b_sync;
  logic [1:0]                  mode;
  logic [NUM_CH-1:0]           clr;
  logic [NUM_CH-1:0]           step_event;
  logic [NUM_CH-1:0]           step_left;
  logic [NUM_CH*POS_WIDTH-1:0] position;
  logic [NUM_CH-1:0]           error;

  modport master (
    output a_sync, b_sync, mode, clr,
    input  step_event, step_left, position, error
  );

  modport slave (
    input  a_sync, b_sync, mode, clr,
    output step_event, step_left, position, error
  );
endinterface

// File: rtl/quad_decoder_array.sv
// Multi-channel quadrature decoder: per-bit saturating contact filter, Gray-code step decode
// with x1/x2/x4 qualification, wrapping signed position and sticky illegal-transition flag.
module quad_decoder_array #(
  parameter int NUM_CH      = 2,
  parameter int FILTER_BITS = 4,
  parameter int POS_WIDTH   = 8
) (
  input logic                 clk,
  input logic                 rst,
  quad_decoder_array_if.slave bus
);
  localparam int SETTLE_W = FILTER_BITS + 2;
  localparam logic [SETTLE_W-1:0]    SETTLE  = SETTLE_W'(2 ** (FILTER_BITS + 1));
  localparam logic [FILTER_BITS-1:0] CNT_MAX = '1;

  logic [SETTLE_W-1:0]         settle_cnt;
  logic                        settled;
  logic [NUM_CH-1:0]           ev_v;
  logic [NUM_CH-1:0]           left_v;
  logic [NUM_CH-1:0]           err_v;
  logic [NUM_CH*POS_WIDTH-1:0] pos_v;

  // Masks events while filters and previous state converge on the real input levels.
  assign settled = (settle_cnt == SETTLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if (!settled) begin
      settle_cnt <= settle_cnt + SETTLE_W'(1);
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [1:0]                  raw;
    logic [1:0]                  filt;
    logic [1:0]                  prev;
    logic [1:0]                  delta;
    logic [1:0][FILTER_BITS-1:0] cnt;
    logic                        qual;
    logic                        count;
    logic                        illegal;
    logic                        left;
    logic                        ev_r;
    logic                        left_r;
    logic                        err_r;
    logic [POS_WIDTH-1:0]        pos_r;

    assign raw = {bus.a_sync[ch], bus.b_sync[ch]};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        filt <= '0;
        cnt  <= '0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (raw[k] == filt[k]) begin
            cnt[k] <= '0;
          end else if (cnt[k] == CNT_MAX) begin
            filt[k] <= raw[k];
            cnt[k]  <= '0;
          end else begin
            cnt[k] <= cnt[k] + FILTER_BITS'(1);
          end
        end
      end
    end

    // State is {A,B}; with one bit changed, prev[1]^filt[0] is 1 exactly on the left sequence.
    always_comb begin
      delta   = filt ^ prev;
      illegal = &delta;
      left    = prev[1] ^ filt[0];
      qual    = 1'b1;
      case (bus.mode)
        2'b00:   qual = (filt == 2'b00);
        2'b01:   qual = (filt == 2'b00) || (filt == 2'b11);
        default: qual = 1'b1;
      endcase
      count = settled && (^delta) && qual;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prev   <= '0;
        ev_r   <= 1'b0;
        left_r <= 1'b0;
        err_r  <= 1'b0;
        pos_r  <= '0;
      end else begin
        prev <= filt;
        ev_r <= count;
        if (count) begin
          left_r <= left;
        end
        if (bus.clr[ch]) begin
          pos_r <= '0;
        end else if (count) begin
          pos_r <= left ? pos_r - POS_WIDTH'(1) : pos_r + POS_WIDTH'(1);
        end
        if (bus.clr[ch]) begin
          err_r <= 1'b0;
        end else if (settled && illegal) begin
          err_r <= 1'b1;
        end
      end
    end

    assign ev_v[ch]                            = ev_r;
    assign left_v[ch]                          = left_r;
    assign err_v[ch]                           = err_r;
    assign pos_v[ch*POS_WIDTH +: POS_WIDTH]    = pos_r;
  end

  assign bus.step_event = ev_v;
  assign bus.step_left  = left_v;
  assign bus.error      = err_v;
  assign bus.position   = pos_v;
endmodule

// File: tb/tb_quad_decoder_array.sv
// Bench for quad_decoder_array: directed scenarios with literal expectations plus random walks,
// all outputs compared every cycle against a history/angle-based reference model.
module tb_quad_decoder_array;
  localparam int NCH    = 2;
  localparam int FB     = 2;
  localparam int PW     = 4;
  localparam int L      = 4;   // filter latency 2^FB
  localparam int SETTLE = 8;   // 2^(FB+1)

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  quad_decoder_array_if #(.NUM_CH(NCH), .POS_WIDTH(PW)) bus();

  quad_decoder_array #(.NUM_CH(NCH), .FILTER_BITS(FB), .POS_WIDTH(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ev_cnt [NCH];

  // Reference model: filtered level flips once the last L samples all disagree with it;
  // steps come from the angular distance between Gray positions.
  logic [1:0]    mf     [NCH];
  logic [1:0]    mp     [NCH];
  logic [L-1:0]  ha     [NCH];
  logic [L-1:0]  hb     [NCH];
  logic          m_ev   [NCH];
  logic          m_left [NCH];
  logic          m_err  [NCH];
  logic [PW-1:0] m_pos  [NCH];
  int            nh;
  int            n_since;
  bit            m_masked;
  bit            m_qual;
  int            m_d;

  function automatic int gidx(logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gst(int i);
    case (i % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        mf[c] = 2'b00; mp[c] = 2'b00; ha[c] = '0; hb[c] = '0;
        m_ev[c] = 1'b0; m_left[c] = 1'b0; m_err[c] = 1'b0; m_pos[c] = '0;
      end
      nh = 0;
      n_since = 0;
    end else begin
      if (n_since < 1000) n_since++;
      m_masked = (n_since <= SETTLE);
      for (int c = 0; c < NCH; c++) begin
        m_d = (gidx(mf[c]) - gidx(mp[c]) + 4) % 4;
        m_ev[c] = 1'b0;
        if (bus.mode == 2'b00)      m_qual = (mf[c] == 2'b00);
        else if (bus.mode == 2'b01) m_qual = (mf[c] == 2'b00) || (mf[c] == 2'b11);
        else                        m_qual = 1'b1;
        if (!m_masked && (m_d == 1 || m_d == 3) && m_qual) begin
          m_ev[c]   = 1'b1;
          m_left[c] = (m_d == 3);
          m_pos[c]  = (m_d == 1) ? m_pos[c] + 1 : m_pos[c] - 1;
        end
        if (!m_masked && m_d == 2) m_err[c] = 1'b1;
        if (bus.clr[c]) begin
          m_pos[c] = '0;
          m_err[c] = 1'b0;
        end
        mp[c] = mf[c];
        ha[c] = {ha[c][L-2:0], bus.a_sync[c]};
        hb[c] = {hb[c][L-2:0], bus.b_sync[c]};
      end
      if (nh < L) nh++;
      for (int c = 0; c < NCH; c++) begin
        if (nh >= L && ha[c] == {L{~mf[c][1]}}) mf[c][1] = ~mf[c][1];
        if (nh >= L && hb[c] == {L{~mf[c][0]}}) mf[c][0] = ~mf[c][0];
      end
    end
  end

  task automatic chk(string name, int c, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s ch%0d at %0t: got %0h expected %0h", name, c, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      chk("step_event", c, 32'(bus.step_event[c]), 32'(m_ev[c]));
      chk("step_left",  c, 32'(bus.step_left[c]),  32'(m_left[c]));
      chk("error",      c, 32'(bus.error[c]),      32'(m_err[c]));
      chk("position",   c, 32'(bus.position[c*PW +: PW]), 32'(m_pos[c]));
      if (bus.step_event[c] === 1'b1) ev_cnt[c]++;
    end
  end

  task automatic wait_cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(int c, logic [1:0] ab);
    bus.a_sync[c] = ab[1];
    bus.b_sync[c] = ab[0];
  endtask

  task automatic walk(int c, logic [7:0] states, int hold);
    for (int k = 0; k < 4; k++) begin
      drive(c, states[7-2*k -: 2]);
      wait_cyc(hold);
    end
  endtask

  task automatic pulse_clr(int c);
    bus.clr[c] = 1'b1;
    wait_cyc(1);
    bus.clr[c] = 1'b0;
  endtask

  task automatic zero_cnt();
    for (int c = 0; c < NCH; c++) ev_cnt[c] = 0;
  endtask

  function automatic logic [PW-1:0] pos_of(int c);
    return bus.position[c*PW +: PW];
  endfunction

  localparam logic [7:0] RIGHT_SEQ = 8'b10_11_01_00;
  localparam logic [7:0] LEFT_SEQ  = 8'b01_11_10_00;

  initial begin
    logic [1:0] cur;
    int r;
    bus.a_sync = '0; bus.b_sync = '0; bus.mode = 2'b10; bus.clr = '0;
    zero_cnt();
    drive(0, 2'b11);
    wait_cyc(3);
    chk("reset_pos", 0, 32'(pos_of(0)), 32'h0);
    chk("reset_err", 0, 32'(bus.error), 32'h0);
    rst = 1'b0;
    wait_cyc(20);
    chk("settle_events", 0, ev_cnt[0], 0);
    chk("settle_err",    0, 32'(bus.error[0]), 32'h0);
    chk("settle_pos",    0, 32'(pos_of(0)), 32'h0);

    drive(0, 2'b01); wait_cyc(6);
    drive(0, 2'b00); wait_cyc(6);
    pulse_clr(0);
    zero_cnt();
    walk(0, RIGHT_SEQ, 6);
    chk("x4_right_events", 0, ev_cnt[0], 4);
    chk("x4_right_dir",    0, 32'(bus.step_left[0]), 32'h0);
    chk("x4_right_pos",    0, 32'(pos_of(0)), 32'h4);
    chk("x4_idle_events",  1, ev_cnt[1], 0);
    chk("x4_idle_pos",     1, 32'(pos_of(1)), 32'h0);

    bus.mode = 2'b00;
    pulse_clr(0);
    zero_cnt();
    walk(0, LEFT_SEQ, 6);
    chk("x1_left_events", 0, ev_cnt[0], 1);
    chk("x1_left_dir",    0, 32'(bus.step_left[0]), 32'h1);
    chk("x1_left_pos",    0, 32'(pos_of(0)), 32'hF);

    bus.mode = 2'b01;
    zero_cnt();
    walk(0, LEFT_SEQ, 6);
    chk("x2_left_events", 0, ev_cnt[0], 2);
    chk("x2_left_pos",    0, 32'(pos_of(0)), 32'hD);

    zero_cnt();
    bus.a_sync[0] = 1'b1; wait_cyc(3);
    bus.a_sync[0] = 1'b0; wait_cyc(6);
    chk("glitch_events", 0, ev_cnt[0], 0);
    chk("glitch_pos",    0, 32'(pos_of(0)), 32'hD);

    drive(0, 2'b11); wait_cyc(6);
    chk("illegal_err",    0, 32'(bus.error[0]), 32'h1);
    chk("illegal_pos",    0, 32'(pos_of(0)), 32'hD);
    chk("illegal_events", 0, ev_cnt[0], 0);
    pulse_clr(0);
    chk("clr_err", 0, 32'(bus.error[0]), 32'h0);
    chk("clr_pos", 0, 32'(pos_of(0)), 32'h0);

    bus.mode = 2'b10;
    zero_cnt();
    walk(0, 8'b01_00_10_11, 6);
    drive(0, 2'b01); wait_cyc(6);
    drive(0, 2'b00); wait_cyc(6);
    drive(0, 2'b10); wait_cyc(6);
    chk("pos_seven", 0, 32'(pos_of(0)), 32'h7);
    drive(0, 2'b11); wait_cyc(6);
    chk("pos_wrap", 0, 32'(pos_of(0)), 32'h8);

    zero_cnt();
    drive(1, 2'b10);
    wait_cyc(3);
    bus.clr[1] = 1'b1;
    wait_cyc(3);
    bus.clr[1] = 1'b0;
    wait_cyc(2);
    chk("clr_step_events", 1, ev_cnt[1], 1);
    chk("clr_step_pos",    1, 32'(pos_of(1)), 32'h0);

    zero_cnt();
    drive(0, 2'b01);
    wait_cyc(2);
    rst = 1'b1;
    #1;
    chk("rst_events", 0, 32'(bus.step_event), 32'h0);
    chk("rst_err",    0, 32'(bus.error), 32'h0);
    chk("rst_pos",    0, 32'(bus.position), 32'h0);
    chk("rst_dir",    0, 32'(bus.step_left), 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    wait_cyc(10);
    chk("post_rst_events0", 0, ev_cnt[0], 0);
    chk("post_rst_events1", 1, ev_cnt[1], 0);
    chk("post_rst_err",     0, 32'(bus.error), 32'h0);
    drive(0, 2'b00); wait_cyc(6);
    chk("resume_pos", 0, 32'(pos_of(0)), 32'h1);

    for (int it = 0; it < 300; it++) begin
      bus.mode = 2'($urandom_range(0, 3));
      for (int c = 0; c < NCH; c++) begin
        cur = {bus.a_sync[c], bus.b_sync[c]};
        r = $urandom_range(0, 9);
        if (r < 4)       drive(c, gst(gidx(cur) + 1));
        else if (r < 7)  drive(c, gst(gidx(cur) + 3));
        else if (r == 7) drive(c, cur ^ 2'b11);
        bus.clr[c] = ($urandom_range(0, 15) == 0);
      end
      if (it == 150) rst = 1'b1;
      wait_cyc(1);
      rst = 1'b0;
      bus.clr = '0;
      wait_cyc($urandom_range(0, 8));
    end
    wait_cyc(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
